multiplicador_algoritmico: RTL
==============================

MULTIPLICADOR_ALGORITMICO -- requirements
Module: multiplicador_algoritmico

Interface
REQ-001 The block SHALL have parameter tamanyo, default 32, giving the operand width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RSTa, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port Coc, input, tamanyo bits: signed quotient operand.
REQ-006 The block SHALL have port Den, input, tamanyo bits: signed divisor operand.
REQ-007 The block SHALL have port Res, input, tamanyo bits: signed remainder operand; present only with MULT_ADD_RES_EN.
REQ-008 The block SHALL have port Num, output, 2*tamanyo bits: signed reconstructed dividend Coc*Den+Res.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking Num valid.

Function
REQ-010 The block SHALL use a four-state FSM: IDLE, CALC, FIX, FIN.
REQ-011 IDLE with Start=1 SHALL load |Coc| and |Den| as tamanyo-bit unsigned magnitudes, the result sign (Coc[msb] XOR Den[msb]) and Res, clear the accumulator, set the counter to tamanyo-1 and go to CALC.
REQ-012 IDLE with Start=0 SHALL hold state, Num and all registers.
REQ-013 CALC SHALL process one multiplier bit per cycle (radix-2 shift-add, LSB first), decrementing the counter and going to FIX after the cycle in which the counter is 0, i.e. after exactly tamanyo cycles.
REQ-014 FIX SHALL negate the 2*tamanyo-bit magnitude product if the sign is 1, add Res sign-extended to 2*tamanyo bits, register the sum into Num and go to FIN.
REQ-015 FIN SHALL assert Done for exactly one cycle and return to IDLE.
REQ-016 Done SHALL go high tamanyo+2 rising edges after the edge that samples Start; the next Start is accepted in the cycle Done is high (IDLE reached the edge after).
REQ-017 Start SHALL be ignored in CALC, FIX and FIN; operand changes during those states SHALL NOT affect the result.
REQ-018 Num SHALL hold its last value from FIX until the next FIX.
REQ-019 The magnitude of -2^(tamanyo-1) SHALL be represented correctly as unsigned 2^(tamanyo-1); Coc=Den=-2^(tamanyo-1) SHALL give +2^(2*tamanyo-2) with no overflow.
REQ-020 Coc=0 or Den=0 SHALL yield Num = sign-extended Res with no special path and normal latency.

Reset
REQ-021 RSTa=0 SHALL immediately force state IDLE, Num=0, Done=0, and clear counter, accumulator and operand registers, including mid-operation.
REQ-022 After RSTa release, the first Start SHALL be serviced normally; the aborted operation SHALL never produce Done.

Configuration
REQ-023 Macro MULT_ADD_RES_EN defined: port Res exists and FIX adds it (Num = Coc*Den+Res).
REQ-024 Macro MULT_ADD_RES_EN undefined: port Res is absent and Num = Coc*Den, with identical latency and FSM.

Structure
REQ-025 Package mult_pkg SHALL hold the FSM state enum typedef (IDLE, CALC, FIX, FIN) and the counter-width constant $clog2(tamanyo).
REQ-026 No sub-module is required; FSM and datapath SHALL reside in multiplicador_algoritmico.

Verification (tamanyo=32, MULT_ADD_RES_EN defined unless noted)
REQ-027 Coc=7, Den=3, Res=2, Start pulse -> Done high 34 edges later, Num=23, Done low the following cycle.
REQ-028 Coc=-7, Den=3, Res=-2 -> Num=-23 (0xFFFF_FFFF_FFFF_FFE9); Coc=-2^31, Den=-1, Res=0 -> Num=0x0000_0000_8000_0000.
REQ-029 Start held high and operands changed during CALC -> exactly one Done per accepted Start, result from the operands loaded in IDLE.
REQ-030 RSTa pulsed low 10 cycles after Start -> Num=0, Done=0 at once; no Done for that operation; a new Start with Coc=5, Den=5, Res=0 -> Num=25.
REQ-031 Den=0, Coc=123, Res=-4 -> Num=-4; with MULT_ADD_RES_EN undefined, Coc=7, Den=3 -> Num=21.
REQ-032 Random back-to-back signed operands (Start asserted in each Done cycle) -> Num equals the reference Coc*Den+Res for every operation.

Source files
------------

// File: rtl/multiplicador_algoritmico_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The state enum and counter sizing live here so the bench and future blocks agree on them.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam int TAMANYO_DEF = 32;
   localparam int CNT_W       = $clog2(TAMANYO_DEF);

   // Counter width for an arbitrary operand width; never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multiplicador_algoritmico.sv
// Signed multiplier by radix-2 shift-add, one multiplier bit per cycle, rebuilding Coc*Den(+Res).
// Optional feature: define MULT_ADD_RES_EN to add the Res port and fold the remainder into Num.
module multiplicador_algoritmico
   import mult_pkg::*;
#(
   parameter int tamanyo = TAMANYO_DEF
) (
   input  logic                   CLK,
   input  logic                   RSTa,
   input  logic                   Start,
   input  logic [tamanyo-1:0]     Coc,
   input  logic [tamanyo-1:0]     Den,
`ifdef MULT_ADD_RES_EN
   input  logic [tamanyo-1:0]     Res,
`endif
   output logic [2*tamanyo-1:0]   Num,
   output logic                   Done
);

   localparam int CW = cnt_width(tamanyo);

   state_t                 state;
   state_t                 state_next;
   logic [CW-1:0]          count;
   logic [2*tamanyo-1:0]   mcand;
   logic [tamanyo-1:0]     mplier;
   logic [2*tamanyo-1:0]   acc;
   logic                   sign;
   logic [tamanyo-1:0]     res_q;
   logic [2*tamanyo-1:0]   num_q;
   logic                   done_q;

   logic [tamanyo-1:0]     coc_mag;
   logic [tamanyo-1:0]     den_mag;
   logic [2*tamanyo-1:0]   res_ext;
   logic [2*tamanyo-1:0]   prod_signed;

   // Two's-complement negation of the most negative value yields 2^(tamanyo-1), exact as unsigned
   always_comb begin
      coc_mag     = Coc[tamanyo-1] ? (~Coc + 1'b1) : Coc;
      den_mag     = Den[tamanyo-1] ? (~Den + 1'b1) : Den;
      prod_signed = sign ? (~acc + 1'b1) : acc;
      res_ext     = {{tamanyo{res_q[tamanyo-1]}}, res_q};
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (Start) state_next = CALC;
         CALC: if (count == '0) state_next = FIX;
         FIX:  state_next = FIN;
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Done is registered out of FIN, so it is high during the first IDLE cycle and a new Start is taken then
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         sign   <= 1'b0;
         res_q  <= '0;
         num_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == FIN);
         case (state)
            IDLE: begin
               if (Start) begin
                  mcand  <= {{tamanyo{1'b0}}, coc_mag};
                  mplier <= den_mag;
                  sign   <= Coc[tamanyo-1] ^ Den[tamanyo-1];
                  acc    <= '0;
                  count  <= CW'(tamanyo - 1);
`ifdef MULT_ADD_RES_EN
                  res_q  <= Res;
`else
                  res_q  <= '0;
`endif
               end
            end
            CALC: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - CW'(1);
            end
            FIX: begin
               num_q <= prod_signed + res_ext;
            end
            default: begin
            end
         endcase
      end
   end

   assign Num  = num_q;
   assign Done = done_q;

endmodule
